// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: datapath widths, bubble/halt encodings, fetch FSM states.
// No logic here; constants and types only.
package fetch_stage_pkg;

    localparam int              CPU_PC_WIDTH    = 16;
    localparam int              CPU_INSTR_WIDTH = 16;
    localparam logic [15:0]     CPU_NOP_INSTR   = 16'h0000;
    localparam logic [3:0]      CPU_HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Priority fetch-address select (branch > hold > sequential) plus the next sequential PC.
// Purely combinational, zero latency; no flow control of its own.
// Hold re-reads the address already in flight so memory data stays coherent with fetch_pc.
module pc_next_mux #(
    parameter int PC_WIDTH = 16
) (
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                hold,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] addr,
    output logic [PC_WIDTH-1:0] next_pc
);

    always_comb begin
        addr = pc;
        if (branch_taken) begin
            addr = branch_target;
        end else if (hold) begin
            addr = fetch_pc;
        end
    end

    // Increment wraps naturally at 2^PC_WIDTH.
    always_comb begin
        next_pc = addr + PC_WIDTH'(1);
        if (hold && !branch_taken) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, synchronous imem address, one instruction/cycle to FetchDecode; optional FETCH_PERF_CNT_EN counter.
// Latency: first valid instruction one cycle after reset release; branches cost one bubble.
// Backpressure: stall holds output and PC with zero latency; branch overrides stall; halt opcode freezes fetch until a branch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = CPU_PC_WIDTH,
    parameter int                     INSTR_WIDTH = CPU_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = CPU_NOP_INSTR,
    parameter logic [3:0]             HALT_OPCODE = CPU_HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetched_count
`endif
);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic                  valid_q;
    logic                  hold;
    logic                  out_live;
    logic                  halt_seen;

    assign hold = stall || (state == HALTED);

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_mux (
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hold          (hold),
        .fetch_pc      (fetch_pc),
        .pc            (pc),
        .addr          (imem_addr),
        .next_pc       (pc_nxt)
    );

    // A branch flushes only what is on the output this cycle; registered state is untouched.
    assign out_live        = valid_q && !branch_taken;
    assign valid_out       = out_live;
    assign instruction_out = out_live ? imem_rdata : NOP_INSTR;
    assign pc_out          = fetch_pc;

    assign halt_seen = out_live && !stall &&
                       (imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (halt_seen) state_nxt = HALTED;
            HALTED:  if (branch_taken) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            fetch_pc <= imem_addr;
            valid_q  <= (state_nxt != HALTED);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_count <= '0;
        end else if (valid_out && !stall) begin
            fetched_count <= fetched_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected outputs per cycle, negedge monitor pops and compares.
// A second instance with RESET_PC=FFFF exercises the reset-address wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, branch_taken;
    logic [15:0] branch_target, imem_addr, imem_rdata, instruction_out, pc_out;
    logic        valid_out;

    logic        stall2, branch_taken2;
    logic [15:0] branch_target2, imem_addr2, imem_rdata2, instruction_out2, pc_out2;
    logic        valid_out2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_count, fetched_count2;
`endif

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetched_count   (fetched_count)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall2),
        .branch_taken    (branch_taken2),
        .branch_target   (branch_target2),
        .imem_addr       (imem_addr2),
        .imem_rdata      (imem_rdata2),
        .instruction_out (instruction_out2),
        .pc_out          (pc_out2),
        .valid_out       (valid_out2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetched_count   (fetched_count2)
`endif
    );

    logic [15:0] mem [0:65535];

    always @(posedge clk) begin
        imem_rdata  <= mem[imem_addr];
        imem_rdata2 <= mem[imem_addr2];
    end

    typedef struct {
        logic        v;
        logic [15:0] i;
        logic [15:0] p;
        logic [31:0] c;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] model_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("valid_out", {31'd0, valid_out}, {31'd0, e1.v});
            chk("instruction_out", {16'd0, instruction_out}, {16'd0, e1.i});
            chk("pc_out", {16'd0, pc_out}, {16'd0, e1.p});
`ifdef FETCH_PERF_CNT_EN
            chk("fetched_count", fetched_count, e1.c);
`endif
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            chk("wrap_valid_out", {31'd0, valid_out2}, {31'd0, e2.v});
            chk("wrap_instruction_out", {16'd0, instruction_out2}, {16'd0, e2.i});
            chk("wrap_pc_out", {16'd0, pc_out2}, {16'd0, e2.p});
`ifdef FETCH_PERF_CNT_EN
            chk("wrap_fetched_count", fetched_count2, e2.c);
`endif
        end
    end

    // Expectation for the cycle currently being driven; counter advances at the closing edge.
    task automatic expect_now(input logic v, input logic [15:0] i, input logic [15:0] p);
        q1.push_back('{v, i, p, model_cnt});
        if (v && !stall) model_cnt++;
    endtask

    task automatic step(input logic st, input logic br, input logic [15:0] tgt,
                        input logic v, input logic [15:0] i, input logic [15:0] p);
        @(posedge clk);
        #1;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        expect_now(v, i, p);
    endtask

    task automatic exp2(input logic v, input logic [15:0] i, input logic [15:0] p, input logic [31:0] c);
        q2.push_back('{v, i, p, c});
    endtask

    task automatic do_reset(input logic st, input logic br);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        stall         = st;
        branch_taken  = br;
        branch_target = 16'h0040;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        model_cnt     = 32'd0;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 16'h0000;
        stall2         = 1'b0;
        branch_taken2  = 1'b0;
        branch_target2 = 16'h0000;
        model_cnt      = 32'd0;
        for (int k = 0; k < 65536; k++) mem[k] = 16'h7E7E;
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0003] = 16'h4444;
        mem[16'h0004] = 16'h5555;
        mem[16'h0005] = 16'hF000;
        mem[16'h0006] = 16'h6666;
        mem[16'h0010] = 16'h1010;
        mem[16'h0011] = 16'h1B1B;
        mem[16'h0012] = 16'h1C1C;
        mem[16'hFFFF] = 16'hAAAA;

        do_reset(1'b0, 1'b0);
        expect_now(1'b0, 16'h0000, 16'h0000);
        exp2(1'b0, 16'h0000, 16'hFFFF, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000);
        exp2(1'b1, 16'hAAAA, 16'hFFFF, 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h0001);
        exp2(1'b1, 16'h1111, 16'h0000, 32'd1);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0002);
        exp2(1'b1, 16'h2222, 16'h0001, 32'd2);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0002);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0002);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 16'h0003);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h0004);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 16'h0005);
        // Halted: bubbles until the redirect, which itself is a flushed cycle.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0006);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0006);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000);
        step(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0001);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1010, 16'h0010);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1B1B, 16'h0011);
        // Branch together with stall: branch wins, then sequential fetch wraps FFFF -> 0000.
        step(1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0012);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000);

        do_reset(1'b1, 1'b1);
        expect_now(1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h0001);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q1.size() + q2.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
